// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl
//   SRAM + memory-mapped I/O controller between the CPU datapath (MAR/MDR)
//   and the tristate SRAM pad. A req/ready handshake starts one access.
//   SRAM accesses get WAIT_CYCLES extra cycles, honour byte enables, and
//   address decode routes IO_ADDR (and IO_ADDR-1 when 8 hex digits are
//   present) to the switch / hex-display registers.
//
// Ports
//   Clk, RESET          clock; synchronous active-low reset
//   req, we, be, addr,  access request; all sampled only in IDLE
//   wdata
//   rdata, ready, busy  read data (held), one-cycle completion pulse, busy flag
//   Switches, hex_out   board switches in; hex digit nibbles out (digit 0 in [3:0])
//   CE,UB,LB,OE,WE      SRAM strobes, active-low, registered
//   ADDR                SRAM address (zero-extended CPU address)
//   Data_to_SRAM,       write data to / read data from the tristate pad
//   Data_from_SRAM
//   sram_drive          1 while the pad must be driven (write states only)
//
// The hex registers are 16-bit words; DATA_W is expected to be 16.

module mem_io_ctrl #(
    parameter int                DATA_W      = 16,
    parameter int                CPU_AW      = 16,
    parameter int                SRAM_AW     = 20,
    parameter int                WAIT_CYCLES = 0,
    parameter int                HEX_DIGITS  = 4,
    parameter logic [CPU_AW-1:0] IO_ADDR     = CPU_AW'(16'hFFFF)
) (
    input  logic                    Clk,
    input  logic                    RESET,
    input  logic                    req,
    input  logic                    we,
    input  logic [1:0]              be,
    input  logic [CPU_AW-1:0]       addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    ready,
    output logic                    busy,
    input  logic [DATA_W-1:0]       Switches,
    output logic [4*HEX_DIGITS-1:0] hex_out,
    output logic                    CE,
    output logic                    UB,
    output logic                    LB,
    output logic                    OE,
    output logic                    WE,
    output logic [SRAM_AW-1:0]      ADDR,
    output logic [DATA_W-1:0]       Data_to_SRAM,
    input  logic [DATA_W-1:0]       Data_from_SRAM,
    output logic                    sram_drive
);

    localparam int                HEX_W      = 16;
    localparam bit                HEX_WIDE   = (HEX_DIGITS == 8);
    localparam logic [3:0]        WAIT_N     = 4'(WAIT_CYCLES);
    localparam logic [CPU_AW-1:0] IO_HI_ADDR = IO_ADDR - 1'b1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_IO, S_DONE
    } state_t;

    // Request fields held for the duration of one access.
    typedef struct packed {
        logic              we;
        logic [1:0]        be;
        logic              io_hi;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t           state, state_d;
    req_t             cur;
    logic [3:0]       cnt;
    logic [HEX_W-1:0] hex_lo, hex_hi;

    logic cnt_last, io_lo_hit, io_hi_hit;
    logic ce_d, ub_d, lb_d, oe_d, we_d, drive_d;
    logic [1:0] be_nx;

    assign cnt_last  = (cnt == WAIT_N);
    assign io_lo_hit = (addr == IO_ADDR);
    // Below IO_ADDR is only decoded when the upper hex word exists;
    // otherwise that address falls through to SRAM.
    assign io_hi_hit = HEX_WIDE && (addr == IO_HI_ADDR);

    assign ready = (state == S_DONE);
    assign busy  = (state != S_IDLE);

    generate
        if (HEX_WIDE) begin : g_hex8
            assign hex_out = {hex_hi, hex_lo};
        end else begin : g_hex4
            assign hex_out = hex_lo;
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next state plus next-cycle strobe values. Strobes are decoded from
    // the next state and registered, so the pad sees clean edges aligned
    // with the state they belong to.
    always_comb begin
        state_d = state;
        ce_d    = 1'b1;
        ub_d    = 1'b1;
        lb_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        drive_d = 1'b0;
        be_nx   = (state == S_IDLE) ? be : cur.be;

        case (state)
            S_IDLE:     if (req) state_d = (io_lo_hit || io_hi_hit) ? S_IO :
                                           (we ? S_WR_SETUP : S_RD);
            S_RD:       if (cnt_last) state_d = S_DONE;
            S_WR_SETUP: state_d = S_WR_PULSE;
            S_WR_PULSE: if (cnt_last) state_d = S_WR_HOLD;
            S_WR_HOLD:  state_d = S_DONE;
            S_IO:       state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        case (state_d)
            S_RD: begin
                ce_d = 1'b0;
                oe_d = 1'b0;
                ub_d = ~be_nx[1];
                lb_d = ~be_nx[0];
            end
            S_WR_SETUP, S_WR_PULSE, S_WR_HOLD: begin
                ce_d    = 1'b0;
                ub_d    = ~be_nx[1];
                lb_d    = ~be_nx[0];
                drive_d = 1'b1;
                we_d    = (state_d != S_WR_PULSE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!RESET) begin
            CE           <= 1'b1;
            UB           <= 1'b1;
            LB           <= 1'b1;
            OE           <= 1'b1;
            WE           <= 1'b1;
            sram_drive   <= 1'b0;
            ADDR         <= '0;
            Data_to_SRAM <= '0;
            rdata        <= '0;
            hex_lo       <= '0;
            hex_hi       <= '0;
            cnt          <= '0;
            cur          <= '0;
        end else begin
            CE         <= ce_d;
            UB         <= ub_d;
            LB         <= lb_d;
            OE         <= oe_d;
            WE         <= we_d;
            sram_drive <= drive_d;

            case (state)
                S_IDLE: if (req) begin
                    cur  <= '{we: we, be: be, io_hi: io_hi_hit, wdata: wdata};
                    ADDR <= SRAM_AW'(addr);
                    cnt  <= '0;
                    if (we && !(io_lo_hit || io_hi_hit)) Data_to_SRAM <= wdata;
                end
                S_RD: begin
                    // rdata is captured even with be==00; the byte lanes
                    // only gate what the SRAM drives, not the capture.
                    if (cnt_last) rdata <= Data_from_SRAM;
                    else          cnt   <= cnt + 4'd1;
                end
                S_WR_PULSE: if (!cnt_last) cnt <= cnt + 4'd1;
                S_IO: begin
                    if (cur.we) begin
                        if (cur.io_hi) hex_hi <= cur.wdata[HEX_W-1:0];
                        else           hex_lo <= cur.wdata[HEX_W-1:0];
                    end else begin
                        rdata <= cur.io_hi ? DATA_W'(hex_hi) : Switches;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
